dn_route_cfg: RTL and testbench

Configuration sequencer directly upstream of the distribution-network 2x2 routers. It accepts per-stage routing words over a valid/ready stream into a shadow buffer, then commits them to the router column. Commit drives route_signal for every switch and pulses set_en one stage per cycle, stage 0 first. Double buffering keeps the live configuration stable while the next one loads.

---
 rtl/dn_pkg.sv | 18 +
 rtl/dn_route_cfg.sv | 161 ++++++++++++++++
 tb/tb_dn_route_cfg.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dn_pkg.sv
// Shared definitions for the distribution-network configuration path:
// sequencer state encoding, router route-field width and counter sizing.
package dn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    APPLY  = 2'd2,
    ACTIVE = 2'd3
  } dn_state_e;

  localparam int DN_ROUTE_W = 2;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dn_route_cfg.sv
// Configuration sequencer for the 2x2 router column: loads per-stage route
// words into a shadow buffer, commits them, then pulses set_en stage by stage.
module dn_route_cfg
  import dn_pkg::*;
#(
  parameter int NUM_SW    = 4,
  parameter int NUM_STAGE = 3,
  parameter int ROUTE_W   = DN_ROUTE_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              release_cfg,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [ROUTE_W*NUM_SW-1:0]         cfg_data,
  output logic [ROUTE_W*NUM_SW*NUM_STAGE-1:0] route_signal,
  output logic [NUM_STAGE-1:0]              set_en,
  output logic                              route_en,
  output logic                              busy,
  output logic                              done
);

  localparam int CFG_W = ROUTE_W * NUM_SW;
  localparam int RS_W  = CFG_W * NUM_STAGE;
  localparam int CNT_W = cnt_width(NUM_STAGE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_STAGE - 1);

  dn_state_e        state;
  dn_state_e        next_state;
  logic [CFG_W-1:0] shadow [NUM_STAGE];
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] apply_cnt;
  logic             accept;
  logic             last_beat;
  logic             last_apply;
  logic             commit;
  logic [RS_W-1:0]  commit_word;

  assign cfg_ready  = (state == LOAD);
  assign busy       = (state == LOAD) || (state == APPLY);
  assign accept     = cfg_valid && cfg_ready;
  assign last_beat  = (beat_cnt == LAST_CNT);
  assign last_apply = (state == APPLY) && (apply_cnt == LAST_CNT);
  // An abort on the final beat takes priority over committing it.
  assign commit     = accept && last_beat && !release_cfg;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
        else       next_state = IDLE;
      end
      LOAD: begin
        if (release_cfg) next_state = IDLE;
        else if (commit) next_state = APPLY;
        else             next_state = LOAD;
      end
      APPLY: begin
        if (last_apply) next_state = ACTIVE;
        else            next_state = APPLY;
      end
      ACTIVE: begin
        if (release_cfg) next_state = IDLE;
        else if (start)  next_state = LOAD;
        else             next_state = ACTIVE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat and apply counters; both return to zero on their terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt  <= '0;
      apply_cnt <= '0;
    end else begin
      if (state != LOAD) begin
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= last_beat ? '0 : beat_cnt + CNT_W'(1);
      end else begin
        beat_cnt <= beat_cnt;
      end

      if (state != APPLY) begin
        apply_cnt <= '0;
      end else if (last_apply) begin
        apply_cnt <= '0;
      end else begin
        apply_cnt <= apply_cnt + CNT_W'(1);
      end
    end
  end

  // Shadow buffer capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_STAGE; s++) begin
        shadow[s] <= '0;
      end
    end else if (accept) begin
      shadow[beat_cnt] <= cfg_data;
    end
  end

  // Commit image: shadow contents with the beat being accepted folded in.
  always_comb begin
    commit_word = '0;
    for (int s = 0; s < NUM_STAGE; s++) begin
      if (CNT_W'(s) == beat_cnt) begin
        commit_word[CFG_W*s +: CFG_W] = cfg_data;
      end else begin
        commit_word[CFG_W*s +: CFG_W] = shadow[s];
      end
    end
  end

  // Registered outputs toward the router column.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      route_signal <= '0;
      set_en       <= '0;
      route_en     <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= last_apply;

      if (commit) begin
        route_signal <= commit_word;
      end

      // Walking one: loaded on commit, shifted out past the last stage.
      if (commit) begin
        set_en <= NUM_STAGE'(1);
      end else if (state == APPLY) begin
        set_en <= set_en << 1'b1;
      end else begin
        set_en <= '0;
      end

      if (last_apply) begin
        route_en <= 1'b1;
      end else if (((state == LOAD) || (state == ACTIVE)) && release_cfg) begin
        route_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dn_route_cfg.sv
// Directed table-driven bench for dn_route_cfg plus an async-reset sequence.
module tb_dn_route_cfg;

  logic        clk;
  logic        reset;
  logic        start;
  logic        release_cfg;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_data;
  logic [23:0] route_signal;
  logic [2:0]  set_en;
  logic        route_en;
  logic        busy;
  logic        done;

  int total;
  int bad;

  dn_route_cfg #(.NUM_SW(4), .NUM_STAGE(3), .ROUTE_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .release_cfg(release_cfg),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data(cfg_data),
    .route_signal(route_signal),
    .set_en(set_en),
    .route_en(route_en),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rl;
    logic        vl;
    logic [7:0]  data;
    logic        e_ready;
    logic        e_busy;
    logic        e_ren;
    logic        e_done;
    logic [2:0]  e_set;
    logic [23:0] e_rs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, input logic rl, input logic vl, input logic [7:0] d,
                     input logic rdy, input logic bsy, input logic ren, input logic dn,
                     input logic [2:0] se, input logic [23:0] rs);
    vec_t v;
    v.st = st; v.rl = rl; v.vl = vl; v.data = d;
    v.e_ready = rdy; v.e_busy = bsy; v.e_ren = ren; v.e_done = dn;
    v.e_set = se; v.e_rs = rs;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic rdy, input logic bsy, input logic ren,
                         input logic dn, input logic [2:0] se, input logic [23:0] rs);
    chk("cfg_ready", idx, {23'd0, cfg_ready}, {23'd0, rdy});
    chk("busy", idx, {23'd0, busy}, {23'd0, bsy});
    chk("route_en", idx, {23'd0, route_en}, {23'd0, ren});
    chk("done", idx, {23'd0, done}, {23'd0, dn});
    chk("set_en", idx, {21'd0, set_en}, {21'd0, se});
    chk("route_signal", idx, route_signal, rs);
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    start = 1'b0;
    release_cfg = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = 8'h00;
    total = 0;
    bad = 0;

    //   st rl vl data   rdy bsy ren dn set     route_signal
    // basic load, back-to-back beats
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h000000);
    add(1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h000000);
    add(1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h000000);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h000000);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    // reconfigure while active, with gaps in cfg_valid
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 24'hFF3CA5);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 24'h030201);
    // release during APPLY is ignored
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 24'h030201);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100, 24'h030201);
    // start and release together in ACTIVE: release wins
    add(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h030201);
    // abort after one beat, stray cfg_valid in IDLE
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h030201);
    // fresh load after abort starts at stage 0
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b1, 8'hCC, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 24'h030201);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 24'hCCBBAA);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 24'hCCBBAA);

    // outputs held in reset
    repeat (2) @(negedge clk);
    chk_all(-1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h000000);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start       = vecs[i].st;
      release_cfg = vecs[i].rl;
      cfg_valid   = vecs[i].vl;
      cfg_data    = vecs[i].data;
      chk_all(i, vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_ren,
              vecs[i].e_done, vecs[i].e_set, vecs[i].e_rs);
    end

    // async reset between edges while set_en[2] is high in APPLY
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_all(100, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 24'h000000);

    // after reset release, no loading without start
    @(negedge clk);
    reset = 1'b0;
    cfg_valid = 1'b1;
    cfg_data = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cfg_ready_post_rst", 101 + k, {23'd0, cfg_ready}, 24'd0);
      chk("set_en_post_rst", 101 + k, {21'd0, set_en}, 24'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
